jc_phase_monitor: RTL and testbench

JC_PHASE_MONITOR -- requirements
Module: jc_phase_monitor

---
 rtl/jc_phase_monitor.sv | 89 ++++++++
 tb/tb_jc_phase_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/jc_phase_monitor.sv
// Watches a 4-bit Johnson counter: decodes its phase, flags illegal codes and
// broken transitions, and counts completed counter cycles via CEO.
module jc_phase_monitor #(
  parameter int CYC_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             R,
  input  logic             ce_in,
  input  logic [3:0]       q_in,
  input  logic             ceo_in,
  input  logic             clr_err,
  output logic [2:0]       phase,
  output logic             phase_valid,
  output logic             illegal,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CYC_W-1:0] cycles,
  output logic             cycle_wrap
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};

  logic [3:0] q_d;
  logic       ce_d;
  logic       chk_en;
  logic       legal;
  logic [2:0] dec;
  logic [3:0] exp_q;
  logic       err_ev;

  always_comb begin
    legal = 1'b1;
    dec   = 3'd0;
    case (q_in)
      4'b0000: dec = 3'd0;
      4'b0001: dec = 3'd1;
      4'b0011: dec = 3'd2;
      4'b0111: dec = 3'd3;
      4'b1111: dec = 3'd4;
      4'b1110: dec = 3'd5;
      4'b1100: dec = 3'd6;
      4'b1000: dec = 3'd7;
      default: legal = 1'b0;
    endcase
  end

  // Without ce the upstream counter holds, so the same code must reappear.
  assign exp_q  = ce_d ? {q_d[2:0], ~q_d[3]} : q_d;
  assign err_ev = chk_en && (!legal || (q_in != exp_q));

  always_ff @(posedge clk) begin
    if (R) begin
      phase       <= '0;
      phase_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      err_cnt     <= '0;
      cycles      <= '0;
      cycle_wrap  <= 1'b0;
      q_d         <= '0;
      ce_d        <= 1'b0;
      chk_en      <= 1'b0;
    end else begin
      q_d    <= q_in;
      ce_d   <= ce_in;
      chk_en <= 1'b1;

      if (legal) phase <= dec;
      phase_valid <= legal;
      illegal     <= !legal;

      // A new error outranks a coincident clear: the count restarts at one.
      if (err_ev) begin
        seq_err <= 1'b1;
        if (clr_err)              err_cnt <= ERR_W'(1);
        else if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
      end else if (clr_err) begin
        seq_err <= 1'b0;
        err_cnt <= '0;
      end

      if (ceo_in) cycles <= cycles + CYC_W'(1);
      cycle_wrap <= ceo_in && (cycles == CYC_MAX);
    end
  end

endmodule

// File: tb/tb_jc_phase_monitor.sv
// Directed bench for jc_phase_monitor driven by a behavioural Johnson counter.
module tb_jc_phase_monitor;

  logic       clk = 1'b0;
  logic       R = 1'b0;
  logic       ce_in = 1'b0;
  logic [3:0] q_in = 4'd0;
  logic       ceo_in = 1'b0;
  logic       clr_err = 1'b0;
  logic [2:0] phase;
  logic       phase_valid, illegal, seq_err, cycle_wrap;
  logic [3:0] err_cnt;
  logic [7:0] cycles;

  int total = 0;
  int bad = 0;
  logic [3:0] jq = 4'd0;

  always #5 clk = ~clk;

  jc_phase_monitor #(.CYC_W(8), .ERR_W(4)) dut (
    .clk(clk), .R(R), .ce_in(ce_in), .q_in(q_in), .ceo_in(ceo_in),
    .clr_err(clr_err), .phase(phase), .phase_valid(phase_valid),
    .illegal(illegal), .seq_err(seq_err), .err_cnt(err_cnt),
    .cycles(cycles), .cycle_wrap(cycle_wrap)
  );

  function automatic logic [3:0] jnext(input logic [3:0] q);
    return {q[2:0], ~q[3]};
  endfunction

  // One clock: present inputs, take the edge, advance the model counter,
  // then settle 1 time unit past the edge so outputs can be sampled.
  task automatic cyc(input logic ce, input logic clr, input logic ovr,
                     input logic [3:0] oq, input logic ceo_f);
    ce_in   = ce;
    clr_err = clr;
    q_in    = ovr ? oq : jq;
    ceo_in  = ceo_f | (ce && jq == 4'b1111);
    @(posedge clk);
    if (R) jq = 4'd0;
    else if (ce) jq = jnext(jq);
    #1;
  endtask

  task automatic do_reset();
    R = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 4'b0101, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 4'b1010, 1'b1);
    R = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    total++;
    if ({phase, phase_valid, illegal, seq_err, err_cnt, cycles, cycle_wrap} !== '0) begin
      bad++;
      $display("FAIL %s: phase=%0d pv=%b ill=%b serr=%b ecnt=%0d cyc=%0d wrap=%b, want all zero",
               nm, phase, phase_valid, illegal, seq_err, err_cnt, cycles, cycle_wrap);
    end
  endtask

  task automatic test_reset();
    do_reset();
    chk_zero("reset");
  endtask

  task automatic test_sequence();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      total++;
      if (phase !== 3'(i % 8) || phase_valid !== 1'b1 || illegal !== 1'b0 || seq_err !== 1'b0) begin
        bad++;
        $display("FAIL seq[%0d]: phase=%0d pv=%b ill=%b serr=%b, want phase=%0d pv=1 ill=0 serr=0",
                 i, phase, phase_valid, illegal, seq_err, i % 8);
      end
    end
    total++;
    if (cycles !== 8'd2) begin
      bad++;
      $display("FAIL seq_cycles: got %0d want 2", cycles);
    end
  endtask

  task automatic test_illegal();
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 4'b0101, 1'b0);
    total++;
    if (illegal !== 1'b1 || phase_valid !== 1'b0 || phase !== 3'd2 || seq_err !== 1'b1 || err_cnt !== 4'd1) begin
      bad++;
      $display("FAIL illegal_hit: ill=%b pv=%b phase=%0d serr=%b ecnt=%0d, want 1 0 2 1 1",
               illegal, phase_valid, phase, seq_err, err_cnt);
    end
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    total++;
    if (illegal !== 1'b0 || phase_valid !== 1'b1 || phase !== 3'd4 || err_cnt !== 4'd2) begin
      bad++;
      $display("FAIL illegal_after: ill=%b pv=%b phase=%0d ecnt=%0d, want 0 1 4 2",
               illegal, phase_valid, phase, err_cnt);
    end
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    total++;
    if (err_cnt !== 4'd2 || seq_err !== 1'b1 || phase !== 3'd5) begin
      bad++;
      $display("FAIL illegal_resync: ecnt=%0d serr=%b phase=%0d, want 2 1 5", err_cnt, seq_err, phase);
    end
  endtask

  task automatic test_skip();
    cyc(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    total++;
    if (seq_err !== 1'b0 || err_cnt !== 4'd0) begin
      bad++;
      $display("FAIL skip_preclr: serr=%b ecnt=%0d, want 0 0", seq_err, err_cnt);
    end
    while (jq != 4'b0011) cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    jq = 4'b1111;
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    total++;
    if (seq_err !== 1'b1 || err_cnt !== 4'd1 || phase !== 3'd4) begin
      bad++;
      $display("FAIL skip_err: serr=%b ecnt=%0d phase=%0d, want 1 1 4", seq_err, err_cnt, phase);
    end
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    total++;
    if (err_cnt !== 4'd1) begin
      bad++;
      $display("FAIL skip_hold: ecnt=%0d want 1", err_cnt);
    end
    cyc(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    total++;
    if (seq_err !== 1'b0 || err_cnt !== 4'd0) begin
      bad++;
      $display("FAIL skip_clr: serr=%b ecnt=%0d, want 0 0", seq_err, err_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 4'b0101, 1'b1);
      total++;
      if (err_cnt !== 4'((i + 1 > 15) ? 15 : i + 1) || seq_err !== 1'b1) begin
        bad++;
        $display("FAIL sat[%0d]: ecnt=%0d serr=%b, want %0d 1", i, err_cnt, seq_err,
                 (i + 1 > 15) ? 15 : i + 1);
      end
    end
    total++;
    if (cycles !== 8'd20) begin
      bad++;
      $display("FAIL sat_cycles: got %0d want 20", cycles);
    end
    cyc(1'b0, 1'b1, 1'b1, 4'b0101, 1'b0);
    total++;
    if (seq_err !== 1'b1 || err_cnt !== 4'd1) begin
      bad++;
      $display("FAIL clr_vs_err: serr=%b ecnt=%0d, want 1 1", seq_err, err_cnt);
    end
  endtask

  task automatic test_wrap();
    int wraps = 0;
    do_reset();
    for (int i = 0; i < 255; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      if (cycle_wrap === 1'b1) wraps++;
    end
    total++;
    if (cycles !== 8'd255 || wraps != 0) begin
      bad++;
      $display("FAIL wrap_pre: cycles=%0d early_wraps=%0d, want 255 0", cycles, wraps);
    end
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    total++;
    if (cycles !== 8'd0 || cycle_wrap !== 1'b1) begin
      bad++;
      $display("FAIL wrap_hit: cycles=%0d wrap=%b, want 0 1", cycles, cycle_wrap);
    end
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    total++;
    if (cycles !== 8'd0 || cycle_wrap !== 1'b0 || seq_err !== 1'b0 || phase !== 3'd0 || phase_valid !== 1'b1) begin
      bad++;
      $display("FAIL wrap_post: cycles=%0d wrap=%b serr=%b phase=%0d pv=%b, want 0 0 0 0 1",
               cycles, cycle_wrap, seq_err, phase, phase_valid);
    end
  endtask

  task automatic test_midreset();
    do_reset();
    repeat (6) cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    total++;
    if (phase !== 3'd5 || cycles !== 8'd1) begin
      bad++;
      $display("FAIL mid_pre: phase=%0d cycles=%0d, want 5 1", phase, cycles);
    end
    R = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    R = 1'b0;
    chk_zero("mid_reset");
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    total++;
    if (seq_err !== 1'b0 || err_cnt !== 4'd0 || phase !== 3'd0 || phase_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_first: serr=%b ecnt=%0d phase=%0d pv=%b, want 0 0 0 1",
               seq_err, err_cnt, phase, phase_valid);
    end
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    total++;
    if (cycles !== 8'd1 || phase !== 3'd4 || seq_err !== 1'b0) begin
      bad++;
      $display("FAIL mid_resume: cycles=%0d phase=%0d serr=%b, want 1 4 0", cycles, phase, seq_err);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_illegal();
    test_skip();
    test_saturate();
    test_wrap();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
